// File: rtl/latch_bank_write_sched.sv
// Round-robin write scheduler for a bank of level-sensitive latches: SETUP -> PULSE -> HOLD per write.
// Optional word write-protect via LB_LOCK_EN (adds lock_mask port).
module latch_bank_write_sched #(
    parameter  int N_REQ     = 4,
    parameter  int N_WORDS   = 4,
    parameter  int WIDTH     = 8,
    parameter  int PULSE_CYC = 1,
    localparam int AW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef LB_LOCK_EN
    input  logic [N_WORDS-1:0]       lock_mask,
`endif
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic                     busy,
    output logic [N_WORDS-1:0]       latch_en,
    output logic [WIDTH-1:0]         latch_d
);
    localparam int RW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      rr, gnt, pick, cand;
    logic               found;
    logic [AW-1:0]      addr_q, addr_pick;
    logic [WIDTH-1:0]   data_pick;
    logic               drop_q, drop_pick, lock_pick;
    logic [3:0]         cnt;
    logic [N_WORDS-1:0] en_oh, en_d;
    logic [N_REQ-1:0]   gnt_oh, ack_d;
    logic               err_d, busy_d;

    // Search starts just past the last grant, so the previous winner is asked last.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        cand  = rr;
        for (int j = 1; j <= N_REQ; j++) begin
            cand = RW'((int'(rr) + j) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        addr_pick = '0;
        data_pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == RW'(i)) begin
                addr_pick = req_addr[i*AW +: AW];
                data_pick = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        lock_pick = 1'b0;
`ifdef LB_LOCK_EN
        for (int w = 0; w < N_WORDS; w++)
            if (addr_pick == AW'(w) && lock_mask[w])
                lock_pick = 1'b1;
`endif
        drop_pick = ({1'b0, addr_pick} >= (AW+1)'(N_WORDS)) || lock_pick;
    end

    always_comb begin
        for (int w = 0; w < N_WORDS; w++)
            en_oh[w] = (addr_q == AW'(w));
        for (int i = 0; i < N_REQ; i++)
            gnt_oh[i] = (gnt == RW'(i));
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state; dropped writes skip PULSE entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = SETUP;
            SETUP:   state_nxt = drop_q ? HOLD : PULSE;
            PULSE:   if (cnt == 4'(PULSE_CYC - 1)) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs are decoded from the next state and registered, keeping latch_en glitch-free
    always_comb begin
        busy_d = (state_nxt != IDLE);
        en_d   = (state_nxt == PULSE) ? en_oh  : '0;
        ack_d  = (state_nxt == HOLD)  ? gnt_oh : '0;
        err_d  = (state_nxt == HOLD) && drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            latch_en <= '0;
        end else begin
            ack      <= ack_d;
            err      <= err_d;
            busy     <= busy_d;
            latch_en <= en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr      <= RW'(N_REQ - 1);
            gnt     <= '0;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            latch_d <= '0;
            cnt     <= '0;
        end else begin
            cnt <= (state == PULSE) ? cnt + 4'd1 : 4'd0;
            if (state == IDLE && found) begin
                gnt     <= pick;
                addr_q  <= addr_pick;
                drop_q  <= drop_pick;
                latch_d <= data_pick;
            end
            if (state == HOLD)
                rr <= gnt;
        end
    end
endmodule

// File: tb/tb_latch_bank_write_sched.sv
// Directed bench for latch_bank_write_sched: scoreboard of expected writes plus cycle-exact checks.
module tb_latch_bank_write_sched;
  localparam int NR = 4, NW = 4, W = 8, AW = 2;

  typedef struct packed {
    logic [3:0] ack;
    logic       err;
    logic [3:0] en;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, rst_nb = 1'b0;
  logic [NR-1:0]    req = '0, reqb = '0;
  logic [NR*AW-1:0] req_addr = '0, req_addrb = '0;
  logic [NR*W-1:0]  req_data = '0, req_datab = '0;
  logic [NR-1:0]    ack, ackb;
  logic             err, errb, busy, busyb;
  logic [NW-1:0]    latch_en;
  logic [2:0]       latch_enb;
  logic [W-1:0]     latch_d, latch_db;
`ifdef LB_LOCK_EN
  logic [NW-1:0]    lock_mask = '0;
  logic [2:0]       lock_maskb = '0;
`endif

  int   n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  logic [3:0] en_seen = '0;

  always #5 clk = ~clk;

  latch_bank_write_sched #(.N_REQ(NR), .N_WORDS(NW), .WIDTH(W), .PULSE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
`ifdef LB_LOCK_EN
    .lock_mask(lock_mask),
`endif
    .ack(ack), .err(err), .busy(busy), .latch_en(latch_en), .latch_d(latch_d));

  latch_bank_write_sched #(.N_REQ(NR), .N_WORDS(3), .WIDTH(W), .PULSE_CYC(3)) dutb (
    .clk(clk), .rst_n(rst_nb), .req(reqb), .req_addr(req_addrb), .req_data(req_datab),
`ifdef LB_LOCK_EN
    .lock_mask(lock_maskb),
`endif
    .ack(ackb), .err(errb), .busy(busyb), .latch_en(latch_enb), .latch_d(latch_db));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write through instance A and wait (bounded) for its ack; the monitor checks content.
  task automatic wr_a(input int idx, input logic [1:0] a, input logic [7:0] d,
                      input logic e, input logic [3:0] en);
    int n;
    n = 0;
    req_addr[idx*AW +: AW] = a;
    req_data[idx*W +: W]   = d;
    sb.push_back('{ack: 4'(1 << idx), err: e, en: en, data: d});
    req[idx] = 1'b1;
    do begin step(); n++; end while (ack == '0 && n < 20);
    chk("wr_latency", 32'(n), (en == '0) ? 32'd2 : 32'd3);
    req[idx] = 1'b0;
    step();
    step();
  endtask

  // Scoreboard side: every ack on instance A retires one expected write.
  always @(negedge clk) begin
    if (!rst_n) en_seen = '0;
    else begin
      chk("en_onehot", 32'($onehot0(latch_en)), 32'd1);
      en_seen = en_seen | latch_en;
      if (ack != '0) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ack",  32'(ack),     32'(e.ack));
          chk("sb_err",  32'(err),     32'(e.err));
          chk("sb_en",   32'(en_seen), 32'(e.en));
          chk("sb_data", 32'(latch_d), 32'(e.data));
        end
        en_seen = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with every requester asking
    req      = 4'hF;
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step(); step();
    chk("rst_ack",  32'(ack),      32'd0);
    chk("rst_err",  32'(err),      32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_en",   32'(latch_en), 32'd0);
    chk("rst_d",    32'(latch_d),  32'd0);
    for (int g = 0; g < 4; g++)
      sb.push_back('{ack: 4'(1 << g), err: 1'b0, en: 4'(1 << g), data: 8'(8'h11 * (g + 1))});
    rst_n = 1'b1;

    // Contention: grants rotate 0,1,2,3 with a fixed spacing
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      do begin step(); n++; end while (ack == '0 && n < 12);
      chk("cont_gap", 32'(n), (g == 0) ? 32'd3 : 32'd4);
      chk("cont_gnt", 32'(ack), 32'(1 << g));
      req[g] = 1'b0;
    end
    step(); step();

    // Single write, cycle-exact
    req_addr[1*AW +: AW] = 2'd2;
    req_data[1*W +: W]   = 8'hA5;
    sb.push_back('{ack: 4'b0010, err: 1'b0, en: 4'b0100, data: 8'hA5});
    req[1] = 1'b1;
    step();
    chk("t2_setup_d",  32'(latch_d),  32'hA5);
    chk("t2_setup_en", 32'(latch_en), 32'd0);
    chk("t2_busy",     32'(busy),     32'd1);
    step();
    chk("t2_pulse_en", 32'(latch_en), 32'b0100);
    chk("t2_pulse_ack",32'(ack),      32'd0);
    step();
    chk("t2_hold_en",  32'(latch_en), 32'd0);
    chk("t2_ack",      32'(ack),      32'b0010);
    chk("t2_err",      32'(err),      32'd0);
    req[1] = 1'b0;
    step();
    chk("t2_ack_off",  32'(ack),      32'd0);
    chk("t2_keep_d",   32'(latch_d),  32'hA5);
    chk("t2_idle",     32'(busy),     32'd0);

    wr_a(3, 2'd3, 8'hC3, 1'b0, 4'b1000);

`ifdef LB_LOCK_EN
    lock_mask = 4'b0001;
    wr_a(2, 2'd0, 8'h5A, 1'b1, 4'b0000);
    wr_a(2, 2'd1, 8'h6B, 1'b0, 4'b0010);
    lock_mask = 4'b0000;
`endif

    // Instance B (N_WORDS=3, PULSE_CYC=3): reset mid-PULSE
    rst_nb = 1'b1;
    step();
    req_addrb[0 +: AW] = 2'd1;
    req_datab[0 +: W]  = 8'h3C;
    reqb[0] = 1'b1;
    step();
    chk("b_setup_en", 32'(latch_enb), 32'd0);
    chk("b_setup_d",  32'(latch_db),  32'h3C);
    step();
    chk("b_pulse1",   32'(latch_enb), 32'b010);
    step();
    chk("b_pulse2",   32'(latch_enb), 32'b010);
    rst_nb = 1'b0;
    #1;
    chk("b_rst_en",   32'(latch_enb), 32'd0);
    chk("b_rst_busy", 32'(busyb),     32'd0);
    chk("b_rst_d",    32'(latch_db),  32'd0);
    reqb = '0;
    step();
    chk("b_rst_ack",  32'(ackb),      32'd0);
    rst_nb = 1'b1;
    step();
    chk("b_rel_busy", 32'(busyb),     32'd0);
    chk("b_rel_ack",  32'(ackb),      32'd0);

    // Instance B normal write, three-cycle pulse
    req_addrb[1*AW +: AW] = 2'd2;
    req_datab[1*W +: W]   = 8'h81;
    reqb[1] = 1'b1;
    step();
    chk("b_wr_setup", 32'(latch_enb), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("b_wr_pulse", 32'(latch_enb), 32'b100);
    end
    step();
    chk("b_wr_en_off", 32'(latch_enb), 32'd0);
    chk("b_wr_ack",    32'(ackb),      32'b0010);
    chk("b_wr_err",    32'(errb),      32'd0);
    reqb[1] = 1'b0;
    step();

    // Instance B out-of-range address: PULSE skipped, ack with err
    req_addrb[2*AW +: AW] = 2'd3;
    req_datab[2*W +: W]   = 8'h77;
    reqb[2] = 1'b1;
    step();
    chk("b_oor_busy",  32'(busyb),     32'd1);
    chk("b_oor_d",     32'(latch_db),  32'h77);
    chk("b_oor_en0",   32'(latch_enb), 32'd0);
    step();
    chk("b_oor_en1",   32'(latch_enb), 32'd0);
    chk("b_oor_ack",   32'(ackb),      32'b0100);
    chk("b_oor_err",   32'(errb),      32'd1);
    reqb[2] = 1'b0;
    step();
    chk("b_oor_ack0",  32'(ackb),      32'd0);
    chk("b_oor_err0",  32'(errb),      32'd0);
    chk("b_oor_idle",  32'(busyb),     32'd0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
